// File: rtl/fsm_counter_ctrl.sv
// Initiator-side controller for a run/idle/done counter worker.
// Buffers count jobs, issues them one at a time, watches for a hung worker.
module fsm_counter_ctrl #(
    parameter int CNT_W      = 7,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1000,
    parameter int TO_W       = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_valid,
    input  logic [CNT_W-1:0]              i_cnt,
    output logic                          o_ready,
    output logic                          o_run,
    output logic [CNT_W-1:0]              o_num_cnt,
    input  logic                          i_idle,
    input  logic                          i_running,
    input  logic                          i_done,
    input  logic                          i_clear,
    output logic                          o_busy,
    output logic                          o_error,
    output logic                          o_job_done,
    output logic [7:0]                    o_jobs_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ERR
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [CNT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LW-1:0]      r_level;
    logic [TO_W-1:0]    r_to_cnt;
    logic [CNT_W-1:0]   r_num_cnt;
    logic               r_job_done;
    logic [7:0]         r_jobs_done;

    logic               w_full;
    logic               w_empty;
    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_done_evt;
    logic               w_timeout;
    logic               w_unused_running;

    // Worker running flag is observed only.
    assign w_unused_running = i_running;

    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_ready   = reset_n && !w_full && (r_state != S_ERR);
    assign w_push    = i_valid && w_ready && (i_cnt != '0);
    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_done_evt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_done) begin
                    w_next = S_ERR;
                end else if (!w_empty && i_idle) begin
                    w_pop  = 1'b1;
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = i_done ? S_ERR : S_WAIT;
            end
            S_WAIT: begin
                // A completion in the final cycle still counts as success.
                if (i_done) begin
                    w_done_evt = 1'b1;
                    w_next     = S_IDLE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_ERR: begin
                if (i_clear) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_to_cnt    <= '0;
            r_num_cnt   <= '0;
            r_job_done  <= 1'b0;
            r_jobs_done <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_num_cnt <= r_mem[r_rd_ptr];
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            if (r_state == S_ISSUE) begin
                r_to_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            r_job_done <= w_done_evt;
            if (w_done_evt) begin
                r_jobs_done <= r_jobs_done + 8'd1;
            end
        end
    end

    assign o_ready     = w_ready;
    assign o_run       = (r_state == S_ISSUE);
    assign o_num_cnt   = r_num_cnt;
    assign o_busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign o_error     = (r_state == S_ERR);
    assign o_job_done  = r_job_done;
    assign o_jobs_done = r_jobs_done;
    assign o_level     = r_level;

endmodule

// File: tb/tb_fsm_counter_ctrl.sv
// Directed bench for fsm_counter_ctrl with a small behavioural counter worker.
module tb_fsm_counter_ctrl;

    localparam int CNT_W   = 7;
    localparam int TIMEOUT = 1000;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             i_valid = 1'b0;
    logic [CNT_W-1:0] i_cnt = '0;
    logic             o_ready;
    logic             o_run;
    logic [CNT_W-1:0] o_num_cnt;
    logic             i_idle = 1'b1;
    logic             i_running = 1'b0;
    logic             i_done = 1'b0;
    logic             i_clear = 1'b0;
    logic             o_busy;
    logic             o_error;
    logic             o_job_done;
    logic [7:0]       o_jobs_done;
    logic [2:0]       o_level;

    int vecs = 0;
    int errs = 0;

    logic wk_hang = 1'b0;
    logic spur_req = 1'b0;
    int   run_cnt = 0;
    int   issued[$];
    int   wk_left = 0;
    bit   wk_busy = 1'b0;

    fsm_counter_ctrl #(
        .CNT_W(CNT_W),
        .FIFO_DEPTH(4),
        .TIMEOUT(TIMEOUT),
        .TO_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_valid(i_valid),
        .i_cnt(i_cnt),
        .o_ready(o_ready),
        .o_run(o_run),
        .o_num_cnt(o_num_cnt),
        .i_idle(i_idle),
        .i_running(i_running),
        .i_done(i_done),
        .i_clear(i_clear),
        .o_busy(o_busy),
        .o_error(o_error),
        .o_job_done(o_job_done),
        .o_jobs_done(o_jobs_done),
        .o_level(o_level)
    );

    always #5 clk = ~clk;

    // Worker: done pulse cnt+1 cycles after seeing run; hang skips done.
    always @(negedge clk) begin
        if (!reset_n) begin
            i_done    = 1'b0;
            i_idle    = 1'b1;
            i_running = 1'b0;
            wk_busy   = 1'b0;
            wk_left   = 0;
        end else begin
            i_done = spur_req;
            if (o_run) begin
                run_cnt++;
                issued.push_back(int'(o_num_cnt));
                wk_busy   = 1'b1;
                wk_left   = int'(o_num_cnt) + 1;
                i_idle    = 1'b0;
                i_running = 1'b1;
            end else if (wk_busy) begin
                wk_left--;
                if (wk_left == 0) begin
                    wk_busy   = 1'b0;
                    i_idle    = 1'b1;
                    i_running = 1'b0;
                    i_done    = !wk_hang;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int cnt);
        i_valid = 1'b1;
        i_cnt   = CNT_W'(cnt);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        vecs++;
        if (o_ready !== 1'b0) begin
            errs++; $display("FAIL rst_ready: got %0d expected 0", o_ready);
        end
        vecs++;
        if ({o_run, o_busy, o_error, o_job_done} !== 4'b0) begin
            errs++; $display("FAIL rst_flags: got %b expected 0000",
                             {o_run, o_busy, o_error, o_job_done});
        end
        vecs++;
        if (o_level !== 3'd0 || o_jobs_done !== 8'd0 || o_num_cnt !== '0) begin
            errs++; $display("FAIL rst_counts: got lvl %0d jobs %0d num %0d expected 0 0 0",
                             o_level, o_jobs_done, o_num_cnt);
        end
        reset_n = 1'b1;
        tick();
        vecs++;
        if (o_ready !== 1'b1) begin
            errs++; $display("FAIL rst_release_ready: got %0d expected 1", o_ready);
        end
    endtask

    task automatic test_single();
        int base;
        int n;
        base = run_cnt;
        push(100);
        vecs++;
        if (o_level !== 3'd1 || o_run !== 1'b0) begin
            errs++; $display("FAIL single_queued: got lvl %0d run %0d expected 1 0",
                             o_level, o_run);
        end
        tick();
        vecs++;
        if (o_run !== 1'b1 || o_num_cnt !== 7'd100 || o_busy !== 1'b1) begin
            errs++; $display("FAIL single_issue: got run %0d num %0d busy %0d expected 1 100 1",
                             o_run, o_num_cnt, o_busy);
        end
        n = 0;
        while (!o_job_done && n < 300) begin
            tick();
            n++;
        end
        vecs++;
        if (n !== 102) begin
            errs++; $display("FAIL single_latency: got %0d cycles expected 102", n);
        end
        vecs++;
        if (o_jobs_done !== 8'd1 || o_busy !== 1'b0 || run_cnt - base !== 1) begin
            errs++; $display("FAIL single_end: got jobs %0d busy %0d runs %0d expected 1 0 1",
                             o_jobs_done, o_busy, run_cnt - base);
        end
        tick();
        vecs++;
        if (o_job_done !== 1'b0) begin
            errs++; $display("FAIL single_pulse: got %0d expected 0", o_job_done);
        end
    endtask

    task automatic test_fifo_full();
        int vals[5];
        int base;
        int nb;
        int n;
        vals = '{10, 20, 30, 40, 50};
        base = run_cnt;
        nb   = issued.size();
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_cnt   = CNT_W'(vals[k]);
            vecs++;
            if (o_ready !== 1'b1) begin
                errs++; $display("FAIL full_accept%0d: got %0d expected 1", k, o_ready);
            end
            tick();
        end
        i_cnt = 7'd60;
        vecs++;
        if (o_ready !== 1'b0 || o_level !== 3'd4) begin
            errs++; $display("FAIL full_block: got rdy %0d lvl %0d expected 0 4",
                             o_ready, o_level);
        end
        tick();
        i_valid = 1'b0;
        vecs++;
        if (o_level !== 3'd4) begin
            errs++; $display("FAIL full_refused: got %0d expected 4", o_level);
        end
        n = 0;
        while (o_jobs_done !== 8'd6 && n < 600) begin
            tick();
            n++;
        end
        vecs++;
        if (o_jobs_done !== 8'd6 || run_cnt - base !== 5 || o_level !== 3'd0) begin
            errs++; $display("FAIL full_end: got jobs %0d runs %0d lvl %0d expected 6 5 0",
                             o_jobs_done, run_cnt - base, o_level);
        end
        for (int k = 0; k < 5; k++) begin
            vecs++;
            if (issued[nb + k] !== vals[k]) begin
                errs++; $display("FAIL full_order%0d: got %0d expected %0d",
                                 k, issued[nb + k], vals[k]);
            end
        end
        tick();
        tick();
    endtask

    task automatic test_zero_cnt();
        int base;
        int n;
        base = run_cnt;
        push(0);
        vecs++;
        if (o_level !== 3'd0) begin
            errs++; $display("FAIL zero_level: got %0d expected 0", o_level);
        end
        push(3);
        n = 0;
        while (!o_job_done && n < 50) begin
            tick();
            n++;
        end
        vecs++;
        if (run_cnt - base !== 1 || issued[$] !== 3 || o_jobs_done !== 8'd7) begin
            errs++; $display("FAIL zero_runs: got runs %0d num %0d jobs %0d expected 1 3 7",
                             run_cnt - base, issued[$], o_jobs_done);
        end
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int base;
        int n;
        wk_hang = 1'b1;
        push(7);
        push(9);
        vecs++;
        if (o_run !== 1'b1 || o_num_cnt !== 7'd7 || o_level !== 3'd1) begin
            errs++; $display("FAIL to_issue: got run %0d num %0d lvl %0d expected 1 7 1",
                             o_run, o_num_cnt, o_level);
        end
        base = run_cnt + 1;
        n = 0;
        while (!o_error && n < 2000) begin
            tick();
            n++;
        end
        vecs++;
        if (n !== TIMEOUT + 1) begin
            errs++; $display("FAIL to_latency: got %0d cycles expected %0d", n, TIMEOUT + 1);
        end
        vecs++;
        if (o_ready !== 1'b0 || o_busy !== 1'b0 || o_level !== 3'd1) begin
            errs++; $display("FAIL to_state: got rdy %0d busy %0d lvl %0d expected 0 0 1",
                             o_ready, o_busy, o_level);
        end
        tick();
        tick();
        tick();
        vecs++;
        if (o_error !== 1'b1 || run_cnt !== base) begin
            errs++; $display("FAIL to_sticky: got err %0d runs %0d expected 1 %0d",
                             o_error, run_cnt, base);
        end
        wk_hang = 1'b0;
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        vecs++;
        if (o_error !== 1'b0 || o_ready !== 1'b1) begin
            errs++; $display("FAIL to_clear: got err %0d rdy %0d expected 0 1",
                             o_error, o_ready);
        end
        tick();
        vecs++;
        if (o_run !== 1'b1 || o_num_cnt !== 7'd9) begin
            errs++; $display("FAIL to_next: got run %0d num %0d expected 1 9",
                             o_run, o_num_cnt);
        end
        n = 0;
        while (!o_job_done && n < 50) begin
            tick();
            n++;
        end
        vecs++;
        if (o_jobs_done !== 8'd8) begin
            errs++; $display("FAIL to_done: got %0d expected 8", o_jobs_done);
        end
        tick();
    endtask

    task automatic test_spurious_reset();
        spur_req = 1'b1;
        tick();
        spur_req = 1'b0;
        vecs++;
        if (o_error !== 1'b1 || o_ready !== 1'b0) begin
            errs++; $display("FAIL spur_err: got err %0d rdy %0d expected 1 0",
                             o_error, o_ready);
        end
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        vecs++;
        if (o_error !== 1'b0) begin
            errs++; $display("FAIL spur_clear: got %0d expected 0", o_error);
        end
        push(50);
        push(20);
        tick();
        vecs++;
        if (o_busy !== 1'b1 || o_level !== 3'd1 || o_num_cnt !== 7'd50) begin
            errs++; $display("FAIL rstw_pre: got busy %0d lvl %0d num %0d expected 1 1 50",
                             o_busy, o_level, o_num_cnt);
        end
        reset_n = 1'b0;
        #1;
        vecs++;
        if ({o_ready, o_run, o_busy, o_error, o_job_done} !== 5'b0 ||
            o_level !== 3'd0 || o_jobs_done !== 8'd0 || o_num_cnt !== '0) begin
            errs++; $display("FAIL rstw_async: got flags %b lvl %0d jobs %0d num %0d expected 0",
                             {o_ready, o_run, o_busy, o_error, o_job_done},
                             o_level, o_jobs_done, o_num_cnt);
        end
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        vecs++;
        if (o_run !== 1'b0 || o_level !== 3'd0 || o_ready !== 1'b1) begin
            errs++; $display("FAIL rstw_after: got run %0d lvl %0d rdy %0d expected 0 0 1",
                             o_run, o_level, o_ready);
        end
    endtask

    task automatic test_wrap();
        int sent;
        int guard;
        int pulses;
        int base;
        sent   = 0;
        guard  = 0;
        pulses = 0;
        base   = run_cnt;
        i_cnt  = 7'd1;
        while (guard < 6000) begin
            if (o_job_done) pulses++;
            if (sent == 256 && !o_busy && o_level == 3'd0) break;
            i_valid = (sent < 256);
            if (i_valid && o_ready) sent++;
            tick();
            guard++;
        end
        i_valid = 1'b0;
        vecs++;
        if (guard >= 6000) begin
            errs++; $display("FAIL wrap_budget: got %0d cycles expected < 6000", guard);
        end
        vecs++;
        if (pulses !== 256 || run_cnt - base !== 256) begin
            errs++; $display("FAIL wrap_count: got pulses %0d runs %0d expected 256 256",
                             pulses, run_cnt - base);
        end
        vecs++;
        if (o_jobs_done !== 8'd0 || o_error !== 1'b0) begin
            errs++; $display("FAIL wrap_value: got jobs %0d err %0d expected 0 0",
                             o_jobs_done, o_error);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fifo_full();
        test_zero_cnt();
        test_timeout();
        test_spurious_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
